shift_reg_univ: RTL and testbench

- Parametrised universal shift register; successor to the fixed 4-bit serial-in/serial-out shifter.
- Supports hold, shift-up (toward MSB), shift-down (toward LSB) and parallel load, with serial and parallel outputs.
- Built-in shift counter pulses `word_done` after every WIDTH shifts since the last load, for serial framing in SPI/UART-style serialisers.

---
 rtl/shift_reg_univ.sv | 112 +++++++++++
 tb/tb_shift_reg_univ.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift-up, shift-down, parallel load, with a word-framing shift counter.
// Latency: q updates on the enabled rising edge; word_done is registered, so it is high the cycle after the WIDTH-th shift.
// Backpressure: none; en=0 freezes all state and forces word_done low on the next cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (q=RESET_VAL, cnt=0, direction=up, word_done=0)
//   en         cycle enable
//   mode       00 hold, 01 shift-up (toward MSB), 10 shift-down (toward LSB), 11 parallel load
//   si_lsb     serial input entering bit 0 on shift-up
//   si_msb     serial input entering bit WIDTH-1 on shift-down
//   pi         parallel load data
//   rot        (only with SHIFT_REG_UNIV_ROTATE_EN) recirculate the outgoing bit instead of the serial input
//   po         parallel output (= q)
//   so_msb     q[WIDTH-1]
//   so_lsb     q[0]
//   word_done  one-cycle pulse after every WIDTH same-direction shifts since the last load
//
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN adds the rot input.

module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_lsb,
  input  logic             si_msb,
  input  logic [WIDTH-1:0] pi,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] po,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             word_done
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             dir_up;     // direction of the most recent shift; 1 = up
  logic             rot_sel;
  logic             fill_up;    // bit entering position 0 on shift-up
  logic             fill_down;  // bit entering position WIDTH-1 on shift-down
  logic             is_shift;
  logic             shift_up;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign rot_sel = rot;
`else
  assign rot_sel = 1'b0;
`endif

  always_comb begin
    fill_up   = rot_sel ? q[WIDTH-1] : si_lsb;
    fill_down = rot_sel ? q[0]       : si_msb;
    is_shift  = (mode == MODE_UP) || (mode == MODE_DOWN);
    shift_up  = (mode == MODE_UP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= RESET_VAL;
      cnt       <= '0;
      dir_up    <= 1'b1;
      word_done <= 1'b0;
    end else if (en) begin
      word_done <= 1'b0;
      case (mode)
        MODE_UP:   q <= {q[WIDTH-2:0], fill_up};
        MODE_DOWN: q <= {fill_down, q[WIDTH-1:1]};
        MODE_LOAD: begin
          q   <= pi;
          cnt <= '0;
        end
        MODE_HOLD: ;
        default:   ;
      endcase
      if (is_shift) begin
        if (shift_up == dir_up) begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            word_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          // A direction change starts a new word; this shift is its first.
          cnt    <= CW'(1);
          dir_up <= shift_up;
        end
      end
    end else begin
      word_done <= 1'b0;
    end
  end

  assign po     = q;
  assign so_msb = q[WIDTH-1];
  assign so_lsb = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       si_lsb;
  logic       si_msb;
  logic [7:0] pi8;
  logic       rot;

  logic [3:0] po4;
  logic       so_msb4, so_lsb4, wd4;
  logic [7:0] po8;
  logic       so_msb8, so_lsb8, wd8;

  int errors = 0;
  int checks = 0;

  shift_reg_univ #(.WIDTH(4), .RESET_VAL(4'hA)) dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .si_lsb(si_lsb), .si_msb(si_msb), .pi(pi8[3:0]),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot(rot),
`endif
    .po(po4), .so_msb(so_msb4), .so_lsb(so_lsb4), .word_done(wd4)
  );

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h3C)) dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .si_lsb(si_lsb), .si_msb(si_msb), .pi(pi8),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot(rot),
`endif
    .po(po8), .so_msb(so_msb8), .so_lsb(so_lsb8), .word_done(wd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Reference model: register as an integer value; the word framing is the
  // length of the current run of same-direction shifts, a word ends whenever
  // that run length is a multiple of the width.
  int          m_w[2] = '{4, 8};
  logic [63:0] m_rv[2] = '{64'hA, 64'h3C};
  logic [63:0] m_q[2];
  int          m_run[2];
  bit          m_up[2];
  bit          m_wd[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = m_rv[k]; m_run[k] = 0; m_up[k] = 1'b1; m_wd[k] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] mask;
      logic        b;
      bit          up;
      mask = (64'd1 << m_w[k]) - 64'd1;
      m_wd[k] = 1'b0;
      if (en) begin
        if (mode == 2'b11) begin
          m_q[k] = {56'd0, pi8} & mask;
          m_run[k] = 0;
        end else if (mode == 2'b01 || mode == 2'b10) begin
          up = (mode == 2'b01);
          if (up) begin
            b = rot ? m_q[k][m_w[k]-1] : si_lsb;
            m_q[k] = ((m_q[k] * 2) + {63'd0, b}) & mask;
          end else begin
            b = rot ? m_q[k][0] : si_msb;
            m_q[k] = (m_q[k] / 2) + ({63'd0, b} << (m_w[k] - 1));
          end
          if (up == m_up[k]) begin
            m_run[k] = m_run[k] + 1;
            m_wd[k] = (m_run[k] % m_w[k]) == 0;
          end else begin
            m_up[k] = up;
            m_run[k] = 1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, sample #1 later.
  task automatic step(input logic e, input logic [1:0] md, input logic sl,
                      input logic sm, input logic [7:0] p);
    en = e; mode = md; si_lsb = sl; si_msb = sm; pi8 = p;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 2'b11, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0, 8'h00);
    // word_done is high now; reset between edges must clear it at once
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (po4 !== 4'hA || wd4 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: po=%h wd=%b, want po=a wd=0", po4, wd4);
    end
    checks++;
    if (po8 !== 8'h3C) begin
      errors++;
      $display("FAIL async_reset_w8: po=%h, want 3c", po8);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00, 1, 1, 8'hFF);
      checks++;
      if (po4 !== 4'hA || wd4 !== 1'b0) begin
        errors++;
        $display("FAIL hold_after_reset[%0d]: po=%h wd=%b, want a 0", i, po4, wd4);
      end
    end
  endtask

  task automatic test_shift_up_word();
    logic [3:0] bits;
    bits = 4'b1011;
    do_reset();
    step(1, 2'b11, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01, bits[3-i], 1, 8'h00);
      checks++;
      if (wd4 !== (i == 3)) begin
        errors++;
        $display("FAIL up_word_wd[%0d]: wd=%b, want %b", i, wd4, (i == 3));
      end
    end
    checks++;
    if (po4 !== 4'b1011 || so_msb4 !== 1'b1) begin
      errors++;
      $display("FAIL up_word_po: po=%b so_msb=%b, want 1011 1", po4, so_msb4);
    end
    step(1, 2'b00, 0, 0, 8'h00);
    checks++;
    if (wd4 !== 1'b0) begin
      errors++;
      $display("FAIL up_word_pulse_width: wd=%b, want 0", wd4);
    end
  endtask

  task automatic test_dir_change();
    do_reset();
    step(1, 2'b11, 0, 0, 8'h09);
    step(1, 2'b10, 1, 0, 8'h00);
    step(1, 2'b10, 1, 0, 8'h00);
    checks++;
    if (po4 !== 4'b0010 || wd4 !== 1'b0) begin
      errors++;
      $display("FAIL down2: po=%b wd=%b, want 0010 0", po4, wd4);
    end
    step(1, 2'b01, 1, 1, 8'h00);
    checks++;
    if (po4 !== 4'b0101 || wd4 !== 1'b0) begin
      errors++;
      $display("FAIL dir_change_up: po=%b wd=%b, want 0101 0", po4, wd4);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b01, 0, 1, 8'h00);
      checks++;
      if (wd4 !== (i == 2)) begin
        errors++;
        $display("FAIL dir_change_wd[%0d]: wd=%b, want %b", i, wd4, (i == 2));
      end
    end
  endtask

  task automatic test_enable_w8();
    logic [7:0] frozen;
    do_reset();
    step(1, 2'b11, 0, 0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        frozen = po8;
        for (int j = 0; j < 2; j++) begin
          step(0, 2'b01, 1, 1, 8'h00);
          checks++;
          if (po8 !== frozen || wd8 !== 1'b0) begin
            errors++;
            $display("FAIL en_freeze[%0d]: po=%h wd=%b, want %h 0", j, po8, wd8, frozen);
          end
        end
      end
      step(1, 2'b01, 0, 0, 8'h00);
      checks++;
      if (wd8 !== (i == 7)) begin
        errors++;
        $display("FAIL en_word1_wd[%0d]: wd=%b, want %b", i, wd8, (i == 7));
      end
    end
    checks++;
    if (po8 !== 8'h00) begin
      errors++;
      $display("FAIL en_word1_po: po=%h, want 00", po8);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, 2'b01, 1, 0, 8'h00);
      checks++;
      if (wd8 !== (i == 7)) begin
        errors++;
        $display("FAIL en_word2_wd[%0d]: wd=%b, want %b", i, wd8, (i == 7));
      end
    end
    checks++;
    if (po8 !== 8'hFF) begin
      errors++;
      $display("FAIL en_word2_po: po=%h, want ff", po8);
    end
  endtask

  task automatic test_load_abort();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, 8'h00);
    step(1, 2'b11, 0, 0, 8'h05);
    checks++;
    if (po4 !== 4'h5 || wd4 !== 1'b0) begin
      errors++;
      $display("FAIL load_abort: po=%h wd=%b, want 5 0", po4, wd4);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01, 0, 0, 8'h00);
      checks++;
      if (wd4 !== (i == 3)) begin
        errors++;
        $display("FAIL load_restart_wd[%0d]: wd=%b, want %b", i, wd4, (i == 3));
      end
    end
    en = 1'b1; mode = 2'b01; si_lsb = 1'b1;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (po4 !== 4'hA || po8 !== 8'h3C) begin
      errors++;
      $display("FAIL reset_mid_shift: po4=%h po8=%h, want a 3c", po4, po8);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  task automatic test_rotate();
    logic [3:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    step(1, 2'b11, 0, 0, 8'h08);
    rot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b01, 0, 1, 8'h00);
      checks++;
      if (po4 !== exp_seq[i] || wd4 !== (i == 3)) begin
        errors++;
        $display("FAIL rotate_up[%0d]: po=%b wd=%b, want %b %b", i, po4, wd4, exp_seq[i], (i == 3));
      end
    end
    step(1, 2'b10, 0, 1, 8'h00);
    checks++;
    if (po4 !== 4'b0100) begin
      errors++;
      $display("FAIL rotate_down: po=%b, want 0100", po4);
    end
    rot = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
`ifdef SHIFT_REG_UNIV_ROTATE_EN
      rot = ($urandom_range(0, 3) == 0);
`endif
      step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      checks++;
      if (po4 !== m_q[0][3:0] || wd4 !== m_wd[0] || so_msb4 !== m_q[0][3] || so_lsb4 !== m_q[0][0]) begin
        errors++;
        $display("FAIL random_w4[%0d]: po=%h wd=%b so=%b%b, want %h %b", i, po4, wd4, so_msb4, so_lsb4, m_q[0][3:0], m_wd[0]);
      end
      checks++;
      if (po8 !== m_q[1][7:0] || wd8 !== m_wd[1] || so_msb8 !== m_q[1][7] || so_lsb8 !== m_q[1][0]) begin
        errors++;
        $display("FAIL random_w8[%0d]: po=%h wd=%b so=%b%b, want %h %b", i, po8, wd8, so_msb8, so_lsb8, m_q[1][7:0], m_wd[1]);
      end
      if ($urandom_range(0, 59) == 0) begin
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
      end
    end
    rot = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; si_lsb = 1'b0; si_msb = 1'b0;
    pi8 = 8'h00; rot = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    test_reset();
    test_shift_up_word();
    test_dir_change();
    test_enable_w8();
    test_load_abort();
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
